// File: rtl/mips_regfile_wr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mips_regfile_wr_decode
//  Purpose  : 32 x WIDTH MIPS register file with one-hot write decode, two
//             combinational read ports and a write-pending (RAW) scoreboard.
//             Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
//  Revision : 1.0  initial release
// ============================================================================
module mips_regfile_wr_decode #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic [ADDR_W-1:0]      rd_addr1,
   input  logic [ADDR_W-1:0]      rd_addr2,
   output logic [WIDTH-1:0]       rd_data1,
   output logic [WIDTH-1:0]       rd_data2,
   input  logic                   claim_en,
   input  logic [ADDR_W-1:0]      claim_addr,
   output logic                   pend1,
   output logic                   pend2,
   output logic [(1<<ADDR_W)-1:0] wr_onehot
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0] r_pend;
   logic [DEPTH-1:0] r_wr_onehot;
   logic [DEPTH-1:0] w_dec;
   logic [DEPTH-1:0] w_claim;

   // Bit 0 is masked in both decodes: $0 is hardwired zero and never pending.
   always_comb begin
      w_dec   = '0;
      w_claim = '0;
      if (wr_en)
         w_dec[wr_addr] = 1'b1;
      if (claim_en)
         w_claim[claim_addr] = 1'b1;
      w_dec[0]   = 1'b0;
      w_claim[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            r_regs[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (w_dec[i])
               r_regs[i] <= wr_data;
      end
   end

   // A new claim outranks the write-back retiring an older one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend      <= '0;
         r_wr_onehot <= '0;
      end else begin
         r_pend      <= (r_pend & ~w_dec) | w_claim;
         r_wr_onehot <= w_dec;
      end
   end

   assign wr_onehot = r_wr_onehot;

`ifdef REGFILE_BYPASS_EN
   always_comb begin
      rd_data1 = r_regs[rd_addr1];
      rd_data2 = r_regs[rd_addr2];
      pend1    = r_pend[rd_addr1];
      pend2    = r_pend[rd_addr2];
      if (w_dec[rd_addr1]) begin
         rd_data1 = wr_data;
         if (!w_claim[rd_addr1])
            pend1 = 1'b0;
      end
      if (w_dec[rd_addr2]) begin
         rd_data2 = wr_data;
         if (!w_claim[rd_addr2])
            pend2 = 1'b0;
      end
   end
`else
   assign rd_data1 = r_regs[rd_addr1];
   assign rd_data2 = r_regs[rd_addr2];
   assign pend1    = r_pend[rd_addr1];
   assign pend2    = r_pend[rd_addr2];
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_wr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_regfile_wr_decode
//  Purpose  : Scoreboard bench for mips_regfile_wr_decode against a
//             behavioural register-file model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_regfile_wr_decode;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  rd_addr1, rd_addr2;
   logic [31:0] rd_data1, rd_data2;
   logic        claim_en;
   logic [4:0]  claim_addr;
   logic        pend1, pend2;
   logic [31:0] wr_onehot;

   mips_regfile_wr_decode #(.WIDTH(32), .ADDR_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr1   (rd_addr1),
      .rd_addr2   (rd_addr2),
      .rd_data1   (rd_data1),
      .rd_data2   (rd_data2),
      .claim_en   (claim_en),
      .claim_addr (claim_addr),
      .pend1      (pend1),
      .pend2      (pend2),
      .wr_onehot  (wr_onehot)
   );

   always #5 clk = ~clk;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] exp;
      string       tag;
   } exp_t;
   exp_t sb[$];

   // Reference model: architectural state only.
   logic [31:0] m_reg [32];
   logic [31:0] m_pend;
   logic [31:0] m_onehot;

   function automatic void push(input string tag, input int kind, input logic [31:0] v);
      exp_t e;
      e.cyc  = cyc;
      e.kind = kind;
      e.exp  = v;
      e.tag  = tag;
      sb.push_back(e);
   endfunction

   // Monitor: compares every expectation due by this (mid-cycle) sample point.
   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [31:0] act;
      string       port;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         case (e.kind)
            0:       begin act = rd_data1;         port = "rd_data1";  end
            1:       begin act = rd_data2;         port = "rd_data2";  end
            2:       begin act = {31'd0, pend1};   port = "pend1";     end
            3:       begin act = {31'd0, pend2};   port = "pend2";     end
            default: begin act = wr_onehot;        port = "wr_onehot"; end
         endcase
         checks++;
         if (e.cyc != cyc || act !== e.exp) begin
            errors++;
            $display("FAIL %s/%s cyc=%0d actual=%h expected=%h", e.tag, port, cyc, act, e.exp);
         end
      end
   end

   task automatic step(input string tag, input bit rst,
                       input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input bit ce, input logic [4:0] ca);
      logic [31:0] e1, e2;
      logic        p1, p2;
      rst_n      = !rst;
      wr_en      = we;
      wr_addr    = wa;
      wr_data    = wd;
      rd_addr1   = a1;
      rd_addr2   = a2;
      claim_en   = ce;
      claim_addr = ca;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_reg[i] = '0;
         m_pend   = '0;
         m_onehot = '0;
      end
      e1 = m_reg[a1];
      e2 = m_reg[a2];
      p1 = m_pend[a1];
      p2 = m_pend[a2];
`ifdef REGFILE_BYPASS_EN
      if (!rst && we && wa != 0 && wa == a1) begin
         e1 = wd;
         if (!(ce && ca == a1)) p1 = 1'b0;
      end
      if (!rst && we && wa != 0 && wa == a2) begin
         e2 = wd;
         if (!(ce && ca == a2)) p2 = 1'b0;
      end
`endif
      push(tag, 0, e1);
      push(tag, 1, e2);
      push(tag, 2, {31'd0, p1});
      push(tag, 3, {31'd0, p2});
      push(tag, 4, m_onehot);
      @(posedge clk);
      if (!rst) begin
         if (we) m_pend[wa] = 1'b0;
         if (ce && ca != 0) m_pend[ca] = 1'b1;
         if (we && wa != 0) begin
            m_reg[wa] = wd;
            m_onehot  = 32'h1 << wa;
         end else begin
            m_onehot = '0;
         end
      end
      #1;
   endtask

   initial begin : timeout
      #1000000;
      $display("FAIL timeout cyc=%0d actual=running expected=finished", cyc);
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr1 = '0; rd_addr2 = '0; claim_en = 1'b0; claim_addr = '0;
      @(posedge clk);
      #1;
      step("reset", 1, 1, 5'd5, 32'h0BAD_F00D, 5'd5, 5'd0, 1, 5'd4);
      step("reset_out", 0, 0, 0, 0, 5'd5, 5'd4, 0, 0);

      // Write then read
      step("wr17", 0, 1, 5'd17, 32'h12345678, 5'd0, 5'd17, 0, 0);
      step("rd17", 0, 0, 0, 0, 5'd0, 5'd17, 0, 0);

      // $0 protection
      step("wr0", 0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd17, 1, 5'd0);
      step("rd0", 0, 0, 0, 0, 5'd0, 5'd0, 0, 0);

      // Scoreboard: claim, hold, retire, then simultaneous claim+write
      step("claim9", 0, 0, 0, 0, 5'd9, 5'd9, 1, 5'd9);
      step("pend9a", 0, 0, 0, 0, 5'd9, 5'd8, 1, 5'd9);
      step("pend9b", 0, 0, 0, 0, 5'd9, 5'd9, 0, 0);
      step("wr9", 0, 1, 5'd9, 32'h99, 5'd9, 5'd9, 0, 0);
      step("clr9", 0, 0, 0, 0, 5'd9, 5'd9, 0, 0);
      step("clmwr9", 0, 1, 5'd9, 32'h999, 5'd9, 5'd2, 1, 5'd9);
      step("setwin9", 0, 0, 0, 0, 5'd9, 5'd9, 0, 0);
      step("wr10", 0, 1, 5'd10, 32'hA, 5'd10, 5'd9, 0, 0);
      step("np10", 0, 0, 0, 0, 5'd10, 5'd9, 0, 0);

      // Same-cycle write/read of r3
      step("r3init", 0, 1, 5'd3, 32'h1, 5'd0, 5'd0, 0, 0);
      step("bypass", 0, 1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, 0, 0);
      step("after", 0, 0, 0, 0, 5'd3, 5'd3, 0, 0);

      // Reset asserted mid-cycle, also dropping an in-flight write
      step("wr5", 0, 1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1, 5'd6);
      step("rd5", 0, 0, 0, 0, 5'd5, 5'd6, 0, 0);
      step("rst_mid", 1, 1, 5'd6, 32'h66, 5'd5, 5'd6, 1, 5'd7);
      step("post_rst", 0, 0, 0, 0, 5'd5, 5'd6, 0, 0);

      // Full sweep
      for (int i = 1; i < 32; i++)
         step("sweep_wr", 0, 1, 5'(i), 32'(i) * 32'h01010101, 5'(i - 1), 5'(i), 0, 0);
      for (int i = 0; i < 32; i++)
         step("sweep_rd", 0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0);

      // Random traffic
      for (int n = 0; n < 300; n++)
         step("random", ($urandom_range(0, 63) == 0),
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)));

      wr_en = 1'b0; claim_en = 1'b0;
      for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         checks += 1;
         errors += 1;
         $display("FAIL drain actual=%0d expected=0 pending expectations", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
